// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the UART command responder.
//   - rx_state_t / tx_state_t / asm_state_t : FSM encodings
//   - dbg_t        : packed snapshot of every FSM state, exported by the top
//   - CMD_W, BYTE_W, FRAME_BITS, DEF_BAUD_DIV
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam int CMD_W        = 16;
  localparam int BYTE_W       = 8;
  localparam int FRAME_BITS   = 10;
  localparam int DEF_BAUD_DIV = 5208;  // 100 MHz / 19200 baud

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_XMIT
  } tx_state_t;

  typedef enum logic {
    ASM_WAIT_HI,
    ASM_WAIT_LO
  } asm_state_t;

  typedef struct packed {
    rx_state_t  rx_state;
    tx_state_t  tx_state;
    asm_state_t asm_state;
  } dbg_t;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder_if
// Command/response link between the UART responder and the command processor.
//   cmd         : assembled command {high byte, low byte}
//   cmd_rdy     : level, a new command is valid on cmd
//   clr_cmd_rdy : pulse, consumer has taken cmd
//   resp        : response byte to transmit
//   trmt        : pulse, start transmitting resp
//   tx_done     : level, last response frame has completed
//
// Handshake: cmd_rdy stays high until clr_cmd_rdy (or a new command starts);
// cmd is stable while cmd_rdy is high. trmt is honoured only while the
// transmitter is idle, tx_done drops on an accepted trmt and rises when the
// stop bit has been fully sent.
// ---------------------------------------------------------------------------
interface uart_cmd_responder_if;
  import uart_cmd_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic [BYTE_W-1:0] resp;
  logic              trmt;
  logic              tx_done;

  // Responder side
  modport slave (
    output cmd, cmd_rdy, tx_done,
    input  clr_cmd_rdy, resp, trmt
  );

  // Command processor side
  modport master (
    input  cmd, cmd_rdy, tx_done,
    output clr_cmd_rdy, resp, trmt
  );

endinterface

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// Two-flop RX synchronizer plus the 8N1 receive bit engine.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx           : asynchronous serial input, idle high
//   rx_byte      : last received byte (valid while rx_byte_vld is high)
//   rx_byte_vld  : 1-cycle pulse, good byte received
//   rx_frm_err   : 1-cycle pulse, stop bit sampled as 0, byte discarded
//   start_det    : 1-cycle pulse, falling edge accepted as a start bit
//   rx_state     : current engine state (debug)
// ---------------------------------------------------------------------------
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_byte_vld,
  output logic              rx_frm_err,
  output logic              start_det,
  output rx_state_t         rx_state
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2 - 1);

  logic              rx_ff1_q, rx_ff2_q, rx_prev_q;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;

  logic rx_sync;
  logic rx_fall;

  // Synchronizer and edge-detect flops reset to the idle line level so a
  // reset never fabricates a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1_q  <= 1'b1;
      rx_ff2_q  <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_ff1_q  <= rx;
      rx_ff2_q  <= rx_ff1_q;
      rx_prev_q <= rx_ff2_q;
    end
  end

  assign rx_sync = rx_ff2_q;
  assign rx_fall = rx_prev_q & ~rx_ff2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_byte_vld = 1'b0;
    rx_frm_err  = 1'b0;
    start_det   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          start_det = 1'b1;
          state_d   = RX_START;
          cnt_d     = HALF_BIT;
        end
      end
      RX_START: begin
        // Mid-start-bit re-check rejects glitches shorter than half a bit.
        if (cnt_q == '0) begin
          if (rx_sync) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_BIT;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync, shift_q[BYTE_W-1:1]};  // LSB arrives first
          cnt_d   = FULL_BIT;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'(BYTE_W - 1)) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        // Return to IDLE at mid-stop so a back-to-back start edge is caught.
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          if (rx_sync) begin
            rx_byte_vld = 1'b1;
          end else begin
            rx_frm_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte  = shift_q;
  assign rx_state = state_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
// Knight-side endpoint of the remote command link: assembles two received
// bytes (high first) into a 16-bit command and transmits an 8-bit response.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   RX       : serial input from remote, idle high
//   TX       : serial output to remote, idle high
//   cmd_if   : command/response handshake (slave modport)
//   dbg      : snapshot of RX, TX and assembler FSM states
// Build option:
//   CMD_TIMEOUT_EN : when defined, a half-received command is dropped if the
//                    low byte does not start within TIMEOUT_CYC cycles.
// ---------------------------------------------------------------------------
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
`ifdef CMD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 30 * BAUD_DIV
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  output logic                 TX,
  uart_cmd_responder_if.slave  cmd_if,
  output dbg_t                 dbg
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);

  // ---------------- receive path ----------------
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_byte_vld;
  logic              rx_frm_err;
  logic              start_det;
  rx_state_t         rx_state;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (RX),
    .rx_byte     (rx_byte),
    .rx_byte_vld (rx_byte_vld),
    .rx_frm_err  (rx_frm_err),
    .start_det   (start_det),
    .rx_state    (rx_state)
  );

  // ---------------- command assembler ----------------
  asm_state_t        asm_state_q, asm_state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              rdy_set, rdy_clr;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state_q <= ASM_WAIT_HI;
      hi_q        <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
    end else begin
      asm_state_q <= asm_state_d;
      hi_q        <= hi_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
    end
  end

  always_comb begin
    asm_state_d = asm_state_q;
    hi_d        = hi_q;
    cmd_d       = cmd_q;
    rdy_set     = 1'b0;
`ifdef CMD_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (asm_state_q)
      ASM_WAIT_HI: begin
        if (rx_byte_vld) begin
          hi_d        = rx_byte;
          asm_state_d = ASM_WAIT_LO;
`ifdef CMD_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      ASM_WAIT_LO: begin
        if (rx_byte_vld) begin
          cmd_d       = {hi_q, rx_byte};
          rdy_set     = 1'b1;
          asm_state_d = ASM_WAIT_HI;
        end else if (rx_frm_err) begin
          // hi_q is left as is; the next good byte overwrites it.
          asm_state_d = ASM_WAIT_HI;
        end
`ifdef CMD_TIMEOUT_EN
        else if (start_det) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
          asm_state_d = ASM_WAIT_HI;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: asm_state_d = ASM_WAIT_HI;
    endcase

    // A start bit seen while waiting for a high byte means a new command is
    // under way, so the previous one is withdrawn. Set has priority.
    rdy_clr   = cmd_if.clr_cmd_rdy | (start_det & (asm_state_q == ASM_WAIT_HI));
    cmd_rdy_d = rdy_set | (cmd_rdy_q & ~rdy_clr);
  end

  assign cmd_if.cmd     = cmd_q;
  assign cmd_if.cmd_rdy = cmd_rdy_q;

  // ---------------- transmit engine ----------------
  tx_state_t                tx_state_q, tx_state_d;
  logic [FRAME_BITS-1:0]    tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]               tx_bit_q, tx_bit_d;
  logic                     tx_q, tx_d;
  logic                     tx_done_q, tx_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  // TX is a registered copy of the bit currently on the wire; shifter bit 0
  // is the bit being sent, so the next bit is always tx_shift_q[1].
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (cmd_if.trmt) begin
          tx_shift_d = {1'b1, cmd_if.resp, 1'b0};
          tx_cnt_d   = FULL_BIT;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
          tx_done_d  = 1'b0;
          tx_state_d = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_cnt_q == '0) begin
          if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
            tx_d       = 1'b1;
            tx_done_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_cnt_d   = FULL_BIT;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TX             = tx_q;
  assign cmd_if.tx_done = tx_done_q;

  assign dbg.rx_state  = rx_state;
  assign dbg.tx_state  = tx_state_q;
  assign dbg.asm_state = asm_state_q;

endmodule
